load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_decode.sv | 43 ++++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: op codes, memory select codes,
// FSM states and the default data-memory size.
package lsu_pkg;

  localparam int unsigned AddrLimitDefault = 256;

  typedef enum logic [2:0] {
    OpLw  = 3'b000,
    OpLh  = 3'b001,
    OpLhu = 3'b010,
    OpLb  = 3'b011,
    OpLbu = 3'b100,
    OpSw  = 3'b101,
    OpSh  = 3'b110,
    OpSb  = 3'b111
  } lsu_op_e;

  localparam logic [1:0] InNone = 2'b00;
  localparam logic [1:0] InWord = 2'b01;
  localparam logic [1:0] InHalf = 2'b10;
  localparam logic [1:0] InByte = 2'b11;

  localparam logic [2:0] OutLw   = 3'b000;
  localparam logic [2:0] OutLh   = 3'b001;
  localparam logic [2:0] OutLhu  = 3'b010;
  localparam logic [2:0] OutLb   = 3'b011;
  localparam logic [2:0] OutLbu  = 3'b100;
  localparam logic [2:0] OutHold = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StLoadResp
  } lsu_state_e;

  // Keeps only the bytes a store of the given size actually writes.
  function automatic logic [31:0] size_mask(input logic [2:0] size);
    case (size)
      3'd1:    size_mask = 32'h0000_00ff;
      3'd2:    size_mask = 32'h0000_ffff;
      default: size_mask = 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/lsu_decode.sv
// Combinational request decoder: access size, memory select codes and the
// misalignment / out-of-range fault flag.
module lsu_decode
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = AddrLimitDefault
) (
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  output logic        is_store,
  output logic [2:0]  size,
  output logic [1:0]  inchoice,
  output logic [2:0]  outchoice,
  output logic        fault
);

  logic misaligned;
  logic out_of_range;

  always_comb begin
    is_store  = 1'b0;
    size      = 3'd4;
    inchoice  = InNone;
    outchoice = OutHold;
    unique case (lsu_op_e'(op))
      OpLw:  begin size = 3'd4; outchoice = OutLw;  end
      OpLh:  begin size = 3'd2; outchoice = OutLh;  end
      OpLhu: begin size = 3'd2; outchoice = OutLhu; end
      OpLb:  begin size = 3'd1; outchoice = OutLb;  end
      OpLbu: begin size = 3'd1; outchoice = OutLbu; end
      OpSw:  begin size = 3'd4; is_store = 1'b1; inchoice = InWord; end
      OpSh:  begin size = 3'd2; is_store = 1'b1; inchoice = InHalf; end
      OpSb:  begin size = 3'd1; is_store = 1'b1; inchoice = InByte; end
    endcase
  end

  assign misaligned   = ((size == 3'd4) && (addr[1:0] != 2'b00)) ||
                        ((size == 3'd2) && addr[0]);
  // 33-bit compare so a huge address cannot wrap past the limit.
  assign out_of_range = {1'b0, addr} > (33'(ADDR_LIMIT) - 33'(size));
  assign fault        = misaligned || out_of_range;

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one memory op, drives a
// registered-read data memory and returns a one-cycle completion pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = AddrLimitDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic        resp_valid,
  output logic        resp_is_load,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [1:0]  dmem_inchoice,
  output logic [2:0]  dmem_outchoice,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata
);

  lsu_state_e state_q, state_d;

  logic        dec_is_store;
  logic [2:0]  dec_size;
  logic [1:0]  dec_inchoice;
  logic [2:0]  dec_outchoice;
  logic        dec_fault;

  logic        accept;
  logic        store_done;
  logic        load_done;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic        is_store_q;
  logic [1:0]  inchoice_q;
  logic [2:0]  outchoice_q;
  logic        resp_valid_q;
  logic        resp_is_load_q;
  logic [31:0] resp_rdata_q;
  logic [4:0]  resp_rd_q;
  logic        fault_q;
  logic [31:0] fault_addr_q;

  lsu_decode #(
    .ADDR_LIMIT(ADDR_LIMIT)
  ) u_decode (
    .op       (req_op),
    .addr     (req_addr),
    .is_store (dec_is_store),
    .size     (dec_size),
    .inchoice (dec_inchoice),
    .outchoice(dec_outchoice),
    .fault    (dec_fault)
  );

  assign accept     = req_valid && (state_q == StIdle);
  assign store_done = (state_q == StAccess) && is_store_q;
  assign load_done  = (state_q == StLoadResp) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept && !dec_fault) state_d = StAccess;
      // A store commits even under flush; a flushed load skips its response.
      StAccess:   state_d = (is_store_q || flush) ? StIdle : StLoadResp;
      StLoadResp: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready      = 1'b0;
    dmem_inchoice  = InNone;
    dmem_outchoice = OutHold;
    unique case (state_q)
      StIdle:     req_ready = 1'b1;
      StAccess: begin
        dmem_inchoice  = inchoice_q;
        dmem_outchoice = outchoice_q;
      end
      StLoadResp: ;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_q           <= '0;
      is_store_q     <= 1'b0;
      inchoice_q     <= InNone;
      outchoice_q    <= OutHold;
      resp_valid_q   <= 1'b0;
      resp_is_load_q <= 1'b0;
      resp_rdata_q   <= '0;
      resp_rd_q      <= '0;
      fault_q        <= 1'b0;
      fault_addr_q   <= '0;
    end else begin
      fault_q <= accept && dec_fault;
      if (accept && dec_fault) begin
        fault_addr_q <= req_addr;
      end
      if (accept && !dec_fault) begin
        addr_q      <= req_addr;
        wdata_q     <= req_wdata & size_mask(dec_size);
        rd_q        <= req_rd;
        is_store_q  <= dec_is_store;
        inchoice_q  <= dec_inchoice;
        outchoice_q <= dec_outchoice;
      end
      resp_valid_q   <= store_done || load_done;
      resp_is_load_q <= load_done;
      if (load_done) begin
        resp_rdata_q <= dmem_rdata;
        resp_rd_q    <= rd_q;
      end
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_is_load = resp_is_load_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_rd      = resp_rd_q;
  assign fault        = fault_q;
  assign fault_addr   = fault_addr_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model with registered read,
// vector table plus directed flush/back-to-back/reset sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_is_load;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        fault;
  logic [31:0] fault_addr;
  logic [1:0]  dmem_inchoice;
  logic [2:0]  dmem_outchoice;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDR_LIMIT(256)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_rd        (req_rd),
    .flush         (flush),
    .resp_valid    (resp_valid),
    .resp_is_load  (resp_is_load),
    .resp_rdata    (resp_rdata),
    .resp_rd       (resp_rd),
    .fault         (fault),
    .fault_addr    (fault_addr),
    .dmem_inchoice (dmem_inchoice),
    .dmem_outchoice(dmem_outchoice),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata)
  );

  // Data memory: writes land at the edge, reads register one edge later.
  logic [7:0]  mem [256];
  logic [31:0] mem_rdata = '0;
  logic [7:0]  ma;
  assign ma         = dmem_addr[7:0];
  assign dmem_rdata = mem_rdata;

  always @(posedge clk) begin
    case (dmem_inchoice)
      2'b01: begin
        mem[ma] = dmem_wdata[7:0];         mem[ma + 8'd1] = dmem_wdata[15:8];
        mem[ma + 8'd2] = dmem_wdata[23:16]; mem[ma + 8'd3] = dmem_wdata[31:24];
      end
      2'b10: begin mem[ma] = dmem_wdata[7:0]; mem[ma + 8'd1] = dmem_wdata[15:8]; end
      2'b11: mem[ma] = dmem_wdata[7:0];
      default: ;
    endcase
    case (dmem_outchoice)
      3'b000: mem_rdata <= {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
      3'b001: mem_rdata <= {{16{mem[ma + 8'd1][7]}}, mem[ma + 8'd1], mem[ma]};
      3'b010: mem_rdata <= {16'h0000, mem[ma + 8'd1], mem[ma]};
      3'b011: mem_rdata <= {{24{mem[ma][7]}}, mem[ma]};
      3'b100: mem_rdata <= {24'h000000, mem[ma]};
      default: ;
    endcase
  end

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          acc;
  } fexp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    bit          flt;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 18;
  vec_t  vecs [NV];
  exp_t  exp_q [$];
  fexp_t fexp_q [$];
  exp_t  mon_e;
  fexp_t mon_f;
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    writes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (dmem_inchoice != 2'b00) writes = writes + 1;
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp_valid", {31'b0, resp_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_is_load", {31'b0, resp_is_load}, {31'b0, mon_e.is_load});
          if (mon_e.is_load) begin
            check("resp_rdata", resp_rdata, mon_e.rdata);
            check("resp_rd", {27'b0, resp_rd}, {27'b0, mon_e.rd});
          end
          check("resp_latency", cyc - mon_e.acc, mon_e.lat);
        end
      end
      if (fault) begin
        if (fexp_q.size() == 0) begin
          check("unexpected_fault", {31'b0, fault}, 32'd0);
        end else begin
          mon_f = fexp_q.pop_front();
          check("fault_addr", fault_addr, mon_f.addr);
          check("fault_latency", cyc - mon_f.acc, 0);
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input bit flt, input logic [31:0] rdata,
                       input bit track, output int acc);
    exp_t  e;
    fexp_t f;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    acc       = -1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        acc = cyc + 1;
        if (track && flt) begin
          f.addr = addr;
          f.acc  = acc;
          fexp_q.push_back(f);
        end else if (track) begin
          e.is_load = (op <= 3'b100);
          e.rdata   = rdata;
          e.rd      = rd;
          e.acc     = acc;
          e.lat     = e.is_load ? 2 : 1;
          exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("accept_timeout", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input string p);
    check({p, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    check({p, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    check({p, "_resp_is_load"}, {31'b0, resp_is_load}, 32'd0);
    check({p, "_fault"}, {31'b0, fault}, 32'd0);
    check({p, "_resp_rdata"}, resp_rdata, 32'd0);
    check({p, "_resp_rd"}, {27'b0, resp_rd}, 32'd0);
    check({p, "_fault_addr"}, fault_addr, 32'd0);
    check({p, "_dmem_addr"}, dmem_addr, 32'd0);
    check({p, "_dmem_wdata"}, dmem_wdata, 32'd0);
    check({p, "_dmem_inchoice"}, {30'b0, dmem_inchoice}, 32'd0);
    check({p, "_dmem_outchoice"}, {29'b0, dmem_outchoice}, 32'd7);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int a1;
    int a2;
    int w0;
    int accs [4];

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    //          op      addr          wdata         rd     flt   expected rdata
    vecs[0]  = '{3'b101, 32'h10,       32'h1234_5678, 5'd0,  1'b0, 32'h0};
    vecs[1]  = '{3'b000, 32'h10,       32'h0,         5'd1,  1'b0, 32'h1234_5678};
    vecs[2]  = '{3'b111, 32'h21,       32'h0000_00a5, 5'd0,  1'b0, 32'h0};
    vecs[3]  = '{3'b011, 32'h21,       32'h0,         5'd2,  1'b0, 32'hffff_ffa5};
    vecs[4]  = '{3'b100, 32'h21,       32'h0,         5'd3,  1'b0, 32'h0000_00a5};
    vecs[5]  = '{3'b110, 32'h20,       32'h0000_8001, 5'd0,  1'b0, 32'h0};
    vecs[6]  = '{3'b010, 32'h20,       32'h0,         5'd4,  1'b0, 32'h0000_8001};
    vecs[7]  = '{3'b001, 32'h20,       32'h0,         5'd5,  1'b0, 32'hffff_8001};
    vecs[8]  = '{3'b101, 32'hfc,       32'hcafe_f00d, 5'd0,  1'b0, 32'h0};
    vecs[9]  = '{3'b000, 32'hfc,       32'h0,         5'd6,  1'b0, 32'hcafe_f00d};
    vecs[10] = '{3'b111, 32'hff,       32'hffff_ff5a, 5'd0,  1'b0, 32'h0};
    vecs[11] = '{3'b100, 32'hff,       32'h0,         5'd7,  1'b0, 32'h0000_005a};
    vecs[12] = '{3'b000, 32'hfc,       32'h0,         5'd8,  1'b0, 32'h5afe_f00d};
    vecs[13] = '{3'b111, 32'h100,      32'h0000_0011, 5'd0,  1'b1, 32'h0};
    vecs[14] = '{3'b010, 32'hff,       32'h0,         5'd9,  1'b1, 32'h0};
    vecs[15] = '{3'b001, 32'hfe,       32'h0,         5'd9,  1'b0, 32'h0000_5afe};
    vecs[16] = '{3'b110, 32'h102,      32'h0000_1234, 5'd0,  1'b1, 32'h0};
    vecs[17] = '{3'b011, 32'hffff_ffff, 32'h0,        5'd10, 1'b1, 32'h0};

    repeat (2) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].flt, vecs[i].rdata,
            1'b1, acc);
    end
    idle(4);

    // Faulting requests must never touch memory or leave IDLE.
    w0 = writes;
    issue(3'b000, 32'h12, 32'h0, 5'd1, 1'b1, 32'h0, 1'b1, acc);
    issue(3'b001, 32'h13, 32'h0, 5'd1, 1'b1, 32'h0, 1'b1, acc);
    issue(3'b000, 32'hfd, 32'h0, 5'd1, 1'b1, 32'h0, 1'b1, acc);
    idle(3);
    check("fault_no_write", writes - w0, 0);
    check("fault_stays_idle", {31'b0, req_ready}, 32'd1);

    // req_valid held high across four loads.
    issue(3'b000, 32'h10, 32'h0, 5'd11, 1'b0, 32'h1234_5678, 1'b1, accs[0]);
    check("b2b_ready_low_0", {31'b0, req_ready}, 32'd0);
    issue(3'b010, 32'h20, 32'h0, 5'd12, 1'b0, 32'h0000_8001, 1'b1, accs[1]);
    check("b2b_ready_low_1", {31'b0, req_ready}, 32'd0);
    issue(3'b100, 32'h21, 32'h0, 5'd13, 1'b0, 32'h0000_0080, 1'b1, accs[2]);
    check("b2b_ready_low_2", {31'b0, req_ready}, 32'd0);
    issue(3'b000, 32'hfc, 32'h0, 5'd14, 1'b0, 32'h5afe_f00d, 1'b1, accs[3]);
    check("b2b_ready_low_3", {31'b0, req_ready}, 32'd0);
    for (int i = 1; i < 4; i++) check("b2b_spacing", accs[i] - accs[i-1], 3);
    idle(4);

    // Flush in IDLE does not block acceptance; a store in ACCESS commits anyway.
    flush = 1'b1;
    issue(3'b101, 32'h50, 32'h1122_3344, 5'd0, 1'b0, 32'h0, 1'b1, acc);
    idle(3);
    flush = 1'b0;
    issue(3'b000, 32'h50, 32'h0, 5'd15, 1'b0, 32'h1122_3344, 1'b1, acc);
    idle(4);

    // Flush in ACCESS for a load goes straight back to IDLE.
    issue(3'b000, 32'h10, 32'h0, 5'd16, 1'b0, 32'h0, 1'b0, acc);
    req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_access_ready", {31'b0, req_ready}, 32'd1);
    idle(3);

    // Flush in LOAD_RESP suppresses the response; next request accepted right after.
    issue(3'b000, 32'h10, 32'h0, 5'd17, 1'b0, 32'h0, 1'b0, a1);
    req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    issue(3'b011, 32'h21, 32'h0, 5'd18, 1'b0, 32'hffff_ff80, 1'b1, a2);
    check("flush_resp_reaccept", a2 - a1, 3);
    idle(4);

    // A store response leaves the last load data in place.
    issue(3'b101, 32'h60, 32'h0000_0001, 5'd19, 1'b0, 32'h0, 1'b1, acc);
    idle(3);
    check("rdata_hold", resp_rdata, 32'hffff_ff80);

    // Reset during a store in ACCESS must abandon the write.
    issue(3'b101, 32'h40, 32'hdead_beef, 5'd0, 1'b0, 32'h0, 1'b0, acc);
    req_valid = 1'b0;
    check("access_inchoice_word", {30'b0, dmem_inchoice}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge clk);
    #1;
    check("midrst_mem_unchanged", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3'b000, 32'h40, 32'h0, 5'd20, 1'b0, 32'h0, 1'b1, acc);
    idle(6);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("fault_queue_drained", fexp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
